// File: rtl/transaction_rx_demux.sv
// transaction_rx_demux
// Receive-side demultiplexer for the transaction layer. A single merged
// 12-bit word stream is split by its class field (in_data[11:10]) into four
// per-class FIFOs that the application drains with per-class pop strobes.
// Occupancy drives advisory flow control (almost_full / almost_empty, and a
// registered pause). Per-class pop counters and a drop counter can be read
// by index while the block is IDLE.
//
// Optional feature (compile-time macro RX_PARITY_CHK_EN):
//   defined   - each written word must have even parity over
//               {in_data, in_parity}. A bad word is discarded and counted as
//               a drop, without entering ERROR.
//   undefined - in_parity is ignored and every accepted word is written.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   init                hold the block in INIT, where the thresholds load
//   umbral_bajo/alto    low / high occupancy thresholds (latched in INIT)
//   in_valid/in_data    incoming word and its qualifier
//   in_parity           even-parity bit for in_data (feature only)
//   pause               registered OR of almost_full, advisory to the link
//   pop[3:0]            per-class read strobes
//   data_out0..3        popped word per class
//   valid_out[3:0]      data_outN carries a freshly popped word
//   empty/almost_full/almost_empty[3:0]  per-class occupancy flags
//   req/idx             counter read request and selector
//                       (0..3 pop counters, 4 drop counter, 5..7 read 0)
//   contador/cnt_valid  counter readout and its qualifier
//   state               RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4

module transaction_rx_demux #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2:0]        umbral_bajo,
  input  logic [2:0]        umbral_alto,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              pause,
  input  logic [3:0]        pop,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [3:0]        valid_out,
  output logic [3:0]        empty,
  output logic [3:0]        almost_full,
  output logic [3:0]        almost_empty,
  input  logic              req,
  input  logic [2:0]        idx,
  output logic [CNT_W-1:0]  contador,
  output logic              cnt_valid,
  output logic [2:0]        state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem     [4][DEPTH];
  logic [PTR_W-1:0]  wr_ptr  [4];
  logic [PTR_W-1:0]  rd_ptr  [4];
  logic [OCC_W-1:0]  occ     [4];
  logic [DATA_W-1:0] dout    [4];
  logic [CNT_W-1:0]  pop_cnt [4];
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  cnt_sel;

  logic [2:0] thr_low;
  logic [2:0] thr_high;
  logic [2:0] state_next;

  logic [1:0] wr_cls;
  logic       wr_open;
  logic       accept;
  logic       parity_ok;
  logic       target_full;
  logic       overflow;
  logic       drop;
  logic [3:0] full;
  logic [3:0] push;
  logic [3:0] pop_ok;

  assign data_out0 = dout[0];
  assign data_out1 = dout[1];
  assign data_out2 = dout[2];
  assign data_out3 = dout[3];

`ifdef RX_PARITY_CHK_EN
  assign parity_ok = ~^{in_data, in_parity};
`else
  logic unused_parity;
  assign unused_parity = in_parity;
  assign parity_ok     = 1'b1;
`endif

  // Words are only taken from the link while the FSM is IDLE or ACTIVE.
  assign wr_cls      = in_data[DATA_W-1 -: 2];
  assign wr_open     = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign accept      = in_valid && wr_open;
  assign target_full = full[wr_cls];
  // A parity failure is a soft drop; only a full-FIFO drop is an overflow.
  assign overflow    = accept && parity_ok && target_full;
  assign drop        = accept && (!parity_ok || target_full);

  // Flags come straight from occupancy; a pop only succeeds on a FIFO that
  // already held data before this edge, so there is no fall-through.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i]        = (occ[i] == '0);
      full[i]         = (occ[i] == OCC_FULL);
      almost_full[i]  = (occ[i] >= OCC_W'(thr_high));
      almost_empty[i] = (occ[i] <= OCC_W'(thr_low));
      push[i]         = accept && parity_ok && !full[i] && (wr_cls == 2'(i));
      pop_ok[i]       = pop[i] && !empty[i] && (state != ST_RESET);
    end
  end

  // NOTE: every variable driven in an always_comb gets a value on every path
  // (here via a default first) so no latch is inferred.
  always_comb begin
    cnt_sel = '0;
    if (idx <= 3'd3)      cnt_sel = pop_cnt[idx[1:0]];
    else if (idx == 3'd4) cnt_sel = drop_cnt;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_INIT;
      ST_INIT:  state_next = init ? ST_INIT : ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (init)
          state_next = ST_INIT;
        else if (overflow)
          state_next = ST_ERROR;
        else if (state == ST_IDLE)
          state_next = (in_valid || !(&empty)) ? ST_ACTIVE : ST_IDLE;
        else
          state_next = (!in_valid && (&empty)) ? ST_IDLE : ST_ACTIVE;
      end
      default:  state_next = ST_ERROR;
    endcase
  end

  // NOTE: storage arrays carry no reset; pointers and occupancy are reset,
  // so stale entries are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i]  <= '0;
        rd_ptr[i]  <= '0;
        occ[i]     <= '0;
        dout[i]    <= '0;
        pop_cnt[i] <= '0;
      end
      valid_out <= '0;
      drop_cnt  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop_ok[i]) begin
          dout[i]    <= mem[i][rd_ptr[i]];
          rd_ptr[i]  <= rd_ptr[i] + PTR_W'(1);
          pop_cnt[i] <= pop_cnt[i] + CNT_W'(1);
        end
        valid_out[i] <= pop_ok[i];
        case ({push[i], pop_ok[i]})
          2'b10:   occ[i] <= occ[i] + OCC_W'(1);
          2'b01:   occ[i] <= occ[i] - OCC_W'(1);
          default: occ[i] <= occ[i];
        endcase
      end
      if (drop) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RESET;
      thr_low   <= 3'd1;
      thr_high  <= 3'd6;
      pause     <= 1'b0;
      cnt_valid <= 1'b0;
      contador  <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) begin
        thr_low  <= umbral_bajo;
        thr_high <= umbral_alto;
      end
      pause     <= |almost_full;
      // Counters are only exposed while IDLE; elsewhere the readout holds.
      cnt_valid <= req && (state == ST_IDLE);
      if (req && (state == ST_IDLE)) contador <= cnt_sel;
    end
  end

endmodule

// File: tb/tb_transaction_rx_demux.sv
// Bench for transaction_rx_demux: directed stimulus, a queue-based reference
// model checked on every cycle, plus literal expectations at key points.
module tb_transaction_rx_demux;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              init;
  logic [2:0]        umbral_bajo;
  logic [2:0]        umbral_alto;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic              pause;
  logic [3:0]        pop;
  logic [DATA_W-1:0] data_out0, data_out1, data_out2, data_out3;
  logic [3:0]        valid_out;
  logic [3:0]        empty;
  logic [3:0]        almost_full;
  logic [3:0]        almost_empty;
  logic              req;
  logic [2:0]        idx;
  logic [CNT_W-1:0]  contador;
  logic              cnt_valid;
  logic [2:0]        state;

  always #5 clk = ~clk;

  transaction_rx_demux #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
    .in_valid(in_valid), .in_data(in_data), .in_parity(in_parity),
    .pause(pause), .pop(pop),
    .data_out0(data_out0), .data_out1(data_out1),
    .data_out2(data_out2), .data_out3(data_out3),
    .valid_out(valid_out), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .req(req), .idx(idx), .contador(contador), .cnt_valid(cnt_valid),
    .state(state)
  );

  logic [DATA_W-1:0] dut_dout [4];
  assign dut_dout[0] = data_out0;
  assign dut_dout[1] = data_out1;
  assign dut_dout[2] = data_out2;
  assign dut_dout[3] = data_out3;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mq [4][$];
  logic [DATA_W-1:0] m_dout [4];
  logic [3:0]        m_vout;
  logic [CNT_W-1:0]  m_pcnt [4];
  logic [CNT_W-1:0]  m_drop;
  logic [CNT_W-1:0]  m_cont;
  logic              m_cv;
  logic              m_pause;
  int                m_low, m_high, m_state;
  bit                m_live = 0;
  int                m_sz [4];
  int                m_st, m_cls;
  bit                m_ovf, m_push, m_any, m_par_ok;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        m_dout[i] = '0;
        m_pcnt[i] = '0;
      end
      m_vout = '0; m_drop = '0; m_cont = '0; m_cv = 0; m_pause = 0;
      m_low = 1; m_high = 6; m_state = 0;
      m_live = 1;
    end else begin
      m_st  = m_state;
      m_any = 0;
      m_pause = 0;
      for (int i = 0; i < 4; i++) begin
        m_sz[i] = mq[i].size();
        if (m_sz[i] != 0) m_any = 1;
        if (m_sz[i] >= m_high) m_pause = 1;
      end
      // counter readout sees the counts from before this edge
      if (req && m_st == 2) begin
        if (idx < 4)       m_cont = m_pcnt[idx[1:0]];
        else if (idx == 4) m_cont = m_drop;
        else               m_cont = '0;
        m_cv = 1;
      end else begin
        m_cv = 0;
      end
`ifdef RX_PARITY_CHK_EN
      m_par_ok = ((^{in_data, in_parity}) == 1'b0);
`else
      m_par_ok = 1;
`endif
      m_ovf = 0; m_push = 0; m_cls = int'(in_data[11:10]);
      if (in_valid && (m_st == 2 || m_st == 3)) begin
        if (!m_par_ok) m_drop = m_drop + 1'b1;
        else if (m_sz[m_cls] == DEPTH) begin
          m_drop = m_drop + 1'b1;
          m_ovf = 1;
        end else m_push = 1;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_st != 0 && pop[i] && m_sz[i] > 0) begin
          m_dout[i] = mq[i].pop_front();
          m_vout[i] = 1'b1;
          m_pcnt[i] = m_pcnt[i] + 1'b1;
        end else begin
          m_vout[i] = 1'b0;
        end
      end
      if (m_push) mq[m_cls].push_back(in_data);
      if (m_st == 1) begin
        m_low  = int'(umbral_bajo);
        m_high = int'(umbral_alto);
      end
      case (m_st)
        0: m_state = 1;
        1: m_state = init ? 1 : 2;
        2, 3: begin
          if (init)        m_state = 1;
          else if (m_ovf)  m_state = 4;
          else if (m_st == 2) m_state = (in_valid || m_any) ? 3 : 2;
          else                m_state = (!in_valid && !m_any) ? 2 : 3;
        end
        default: m_state = 4;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [3:0] e_empty, e_afull, e_aempty;
  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < 4; i++) begin
        e_empty[i]  = (mq[i].size() == 0);
        e_afull[i]  = (mq[i].size() >= m_high);
        e_aempty[i] = (mq[i].size() <= m_low);
        check($sformatf("model data_out%0d", i), dut_dout[i], m_dout[i]);
      end
      check("model state", state, m_state);
      check("model valid_out", valid_out, m_vout);
      check("model empty", empty, e_empty);
      check("model almost_full", almost_full, e_afull);
      check("model almost_empty", almost_empty, e_aempty);
      check("model pause", pause, m_pause);
      check("model cnt_valid", cnt_valid, m_cv);
      check("model contador", contador, m_cont);
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_word(input logic [DATA_W-1:0] d);
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = ^d;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; init = 0; umbral_bajo = 0; umbral_alto = 0;
    in_valid = 0; in_data = 0; in_parity = 0; pop = 0; req = 0; idx = 0;
    @(negedge clk); @(negedge clk);
    check("reset state", state, 3'd0);
    check("reset empty", empty, 4'hF);
    check("reset almost_empty", almost_empty, 4'hF);
    check("reset almost_full", almost_full, 4'h0);
    check("reset pause", pause, 1'b0);
    check("reset valid_out", valid_out, 4'h0);

    // init with low=2, high=5
    reset = 0; init = 1; umbral_bajo = 3'd2; umbral_alto = 3'd5;
    @(negedge clk);
    check("init state", state, 3'd1);
    init = 0;
    @(negedge clk);
    check("idle state", state, 3'd2);
    check("idle empty", empty, 4'hF);

    // one word per class, then pop all
    push_word(12'h400); push_word(12'h801); push_word(12'hC02); push_word(12'h003);
    pop = 4'hF;
    @(negedge clk);
    pop = 4'h0;
    check("demux data_out1", data_out1, 12'h400);
    check("demux data_out2", data_out2, 12'h801);
    check("demux data_out3", data_out3, 12'hC02);
    check("demux data_out0", data_out0, 12'h003);
    check("demux valid_out", valid_out, 4'hF);
    check("demux state active", state, 3'd3);
    @(negedge clk);
    check("demux valid_out drop", valid_out, 4'h0);
    check("demux back idle", state, 3'd2);

    // fill class 2 up to the high threshold
    for (int k = 0; k < 5; k++) push_word(12'h800 + 12'(k));
    check("afull class2", almost_full, 4'b0100);
    check("pause lag", pause, 1'b0);
    @(negedge clk);
    check("pause set", pause, 1'b1);

    // overflow on the 9th class-2 word
    for (int k = 5; k < 9; k++) push_word(12'h800 + 12'(k));
    check("overflow state", state, 3'd4);

    // in ERROR: writes and counter reads are ignored, pops still work
    in_valid = 1; in_data = 12'h0FF; in_parity = ^in_data; req = 1; idx = 3'd4;
    @(negedge clk);
    in_valid = 0; req = 0;
    check("error cnt_valid", cnt_valid, 1'b0);
    check("error no write", empty[0], 1'b1);
    pop = 4'b0100;
    @(negedge clk);
    pop = 4'h0;
    check("error pop data", data_out2, 12'h800);
    check("error pop valid", valid_out, 4'b0100);
    check("error sticky", state, 3'd4);

    // reset clears everything, re-init with low=1, high=6
    reset = 1;
    @(negedge clk);
    reset = 0; init = 1; umbral_bajo = 3'd1; umbral_alto = 3'd6;
    @(negedge clk);
    init = 0;
    @(negedge clk);
    check("reinit idle", state, 3'd2);
    req = 1; idx = 3'd2;
    @(negedge clk);
    req = 0;
    check("cleared pop cnt valid", cnt_valid, 1'b1);
    check("cleared pop cnt", contador, 5'd0);

    // three pushes, three pops on class 0
    push_word(12'h011); push_word(12'h022); push_word(12'h033);
    pop = 4'b0001;
    @(negedge clk);
    check("pop0 a", data_out0, 12'h011);
    @(negedge clk);
    check("pop0 b", data_out0, 12'h022);
    @(negedge clk);
    check("pop0 c", data_out0, 12'h033);
    pop = 4'h0;
    @(negedge clk);
    check("pop0 idle", state, 3'd2);
    req = 1; idx = 3'd6;
    @(negedge clk);
    check("idx6 value", contador, 5'd0);
    idx = 3'd0;
    @(negedge clk);
    req = 0;
    check("idx0 value", contador, 5'd3);
    check("idx0 valid", cnt_valid, 1'b1);
    @(negedge clk);
    check("cnt pulse", cnt_valid, 1'b0);

    // push+pop to empty class 1: write only
    in_valid = 1; in_data = 12'h4AA; in_parity = ^in_data; pop = 4'b0010;
    @(negedge clk);
    check("nofall valid", valid_out, 4'h0);
    check("nofall data", data_out1, 12'h000);
    // push+pop to non-empty class 1: both
    in_data = 12'h4BB; in_parity = ^in_data;
    @(negedge clk);
    check("pushpop data", data_out1, 12'h4AA);
    check("pushpop occ", empty[1], 1'b0);
    in_valid = 0; req = 1; idx = 3'd1;
    @(negedge clk);
    pop = 4'h0; req = 0;
    check("pushpop last", data_out1, 12'h4BB);
    check("active req ignored", cnt_valid, 1'b0);
    check("active req holds", contador, 5'd3);

    // streaming through class 3 to wrap its pointers
    for (int k = 0; k < 12; k++) begin
      in_valid = 1; in_data = 12'hC00 + 12'(k); in_parity = ^in_data;
      pop = (k > 0) ? 4'b1000 : 4'b0000;
      @(negedge clk);
    end
    in_valid = 0; pop = 4'b1000;
    @(negedge clk);
    pop = 4'h0;
    check("wrap last", data_out3, 12'hC0B);
    @(negedge clk); @(negedge clk);

`ifdef RX_PARITY_CHK_EN
    in_valid = 1; in_data = 12'h001; in_parity = 1'b0;
    @(negedge clk);
    in_valid = 0;
    check("parity not error", state, 3'd3);
    check("parity discarded", empty[0], 1'b1);
    @(negedge clk);
    req = 1; idx = 3'd4;
    @(negedge clk);
    req = 0;
    check("parity drop cnt", contador, 5'd1);
    in_valid = 1; in_data = 12'h001; in_parity = 1'b1;
    @(negedge clk);
    in_valid = 0; pop = 4'b0001;
    check("parity stored", empty[0], 1'b0);
    @(negedge clk);
    pop = 4'h0;
    check("parity data", data_out0, 12'h001);
    @(negedge clk);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transaction_rx_demux.md
Name: transaction_rx_demux

Overview:
Receive-side counterpart of the transaction-layer TX path. It accepts the single merged 12-bit word stream from the link and decodes the class field. Each word is steered into one of four per-class FIFOs, which the application drains. Buffer occupancy drives advisory flow control back to the link through almost-full/almost-empty thresholds. Per-class pop counters can be read by index, and a small FSM handles init, idle, active and error.

Parameters:
DATA_W, 12, word width; class field is in_data[11:10].
DEPTH, 8, entries per class FIFO (power of two; pointer width 3, occupancy width 4).
CNT_W, 5, width of the per-class pop counters and the drop counter.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
init  in  1  enter/stay in INIT, thresholds load while high
umbral_bajo  in  3  low threshold, almost_empty when occupancy <= value
umbral_alto  in  3  high threshold, almost_full when occupancy >= value
in_valid  in  1  in_data carries a word this cycle
in_data  in  DATA_W  word; [11:10] = class 0..3
in_parity  in  1  even-parity bit over in_data (used only with feature)
pause  out  1  registered OR of almost_full[3:0], advisory backpressure to link
pop  in  4  per-class read strobe
data_out0..data_out3  out  DATA_W each  popped word per class
valid_out  out  4  data_outN valid this cycle
empty  out  4  per-class FIFO empty
almost_full  out  4  per-class occupancy >= latched high threshold
almost_empty  out  4  per-class occupancy <= latched low threshold
req  in  1  counter read request
idx  in  3  0..3 class pop counter, 4 drop counter, 5..7 read as 0
contador  out  CNT_W  counter readout
cnt_valid  out  1  contador valid
state  out  3  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4

Behaviour:
- Reset behaviour while reset=1:
  - state=RESET; FIFOs and pointers flushed; all counters 0.
  - Latched thresholds: low=1, high=6.
  - Outputs: data_out*=0, valid_out=0, cnt_valid=0, contador=0, pause=0; empty=4'hF; almost_empty=4'hF; almost_full=0.
- FSM transitions, priority in order listed:
  - reset -> RESET.
  - RESET -> INIT on first cycle with reset=0.
  - INIT: latch umbral_bajo/umbral_alto every cycle; leave to IDLE when init=0.
  - IDLE/ACTIVE with init=1 -> INIT; FIFO contents are retained.
  - IDLE -> ACTIVE when in_valid=1 or any FIFO is non-empty.
  - ACTIVE -> IDLE when in_valid=0 and all FIFOs are empty.
  - An overflow in IDLE/ACTIVE -> ERROR. ERROR is sticky until reset.
- Write path (only in IDLE/ACTIVE):
  - in_valid=1 writes in_data into FIFO[in_data[11:10]] at the clock edge. pause does not gate the write.
  - If the target FIFO is full (occupancy 8): word dropped, drop counter +1, next state ERROR.
  - in_valid is ignored in RESET, INIT and ERROR; no drop count.
- Read path (active in every state except RESET):
  - pop[i] with FIFO i non-empty: next cycle data_out_i = head word, valid_out[i]=1.
  - Pop on an empty FIFO is ignored: valid_out[i]=0 and data_out_i holds its value.
  - No fall-through: a push and pop to an empty FIFO in the same cycle gives a write only.
  - A push and pop to a non-empty FIFO in the same cycle performs both; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
- Flags:
  - empty, almost_full and almost_empty are combinational from current occupancy and the latched thresholds.
  - pause is registered, so it lags one cycle.
- Counters:
  - Per-class counters increment on each successful pop and wrap modulo 2^CNT_W.
  - The drop counter also wraps.
- Counter read:
  - req=1 in IDLE: next cycle contador = selected counter, cnt_valid=1.
  - req=1 in any other state: next cycle cnt_valid=0 and contador holds.
  - Single-cycle pulse per req cycle.
- Latency: input word to poppable is 1 cycle (empty deasserts the cycle after the write). Pop to data_out is 1 cycle.

Optional Feature:
RX_PARITY_CHK_EN:
- Defined: each written word is checked for even parity (^{in_data,in_parity} must be 0).
  - On mismatch the word is discarded and the drop counter increments.
  - The FSM does NOT go to ERROR and no FIFO is written.
- Undefined: in_parity is ignored and every accepted word is written. The port remains present.

Test Plan:
- Reset then init=1 with umbral_bajo=2, umbral_alto=5, then init=0 -> state 0->1->2; empty=4'hF; almost_empty=4'hF; pause=0.
- Write 0x400, 0x801, 0xC02, 0x003 on consecutive cycles, then pop=4'hF -> data_out1=0x400, data_out2=0x801, data_out3=0xC02, data_out0=0x003; valid_out=4'hF for one cycle; state ACTIVE->IDLE.
- Write 5 words of class 2 (alto=5) -> almost_full[2]=1 after the 5th write, pause=1 one cycle later.
- Write 9 words of class 2 -> 9th word dropped; state=ERROR; req, idx=4 is ignored in ERROR; after reset, counters read 0.
- Pop class 0 three times after three writes, return to IDLE, req=1, idx=0 -> contador=3, cnt_valid=1 one cycle later; idx=6 -> 0.
- With RX_PARITY_CHK_EN: in_data=0x001, in_parity=0 -> dropped, drop counter=1, state not ERROR; in_parity=1 -> stored in class 0.
